// File: rtl/backend_pipe_pkg.sv
// Shared defaults and helpers for the backend pipeline shell.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package backend_pipe_pkg;

    localparam int DEF_NSTAGE      = 3;
    localparam int DEF_PAYLOAD_W   = 256;
    localparam int DEF_RESULT_W    = 64;
    localparam int DEF_LREG_W      = 5;
    localparam int DEF_STALL_STAGE = 1;

    // One stage's worth of state at default widths.
    typedef struct packed {
        logic                     valid;
        logic [DEF_LREG_W-1:0]    rd;
        logic                     need_to_wb;
        logic [DEF_RESULT_W-1:0]  result;
        logic [DEF_PAYLOAD_W-1:0] payload;
    } stage_t;

    // Saturating 32-bit increment, used by the stall counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/backend_pipe_ctrl_stage.sv
// One pipeline stage register with load / hold / bubble / kill / fill controls.
// Latency: 1 cycle from d_* to q_* when load is high.
// Backpressure: load low holds contents; kill clears valid while held; fill rewrites result while held.
module pipe_stage_reg
    import backend_pipe_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int RESULT_W  = DEF_RESULT_W,
    parameter int LREG_W    = DEF_LREG_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 bubble,
    input  logic                 kill,
    input  logic                 fill_en,
    input  logic [RESULT_W-1:0]  fill_data,
    input  logic                 d_valid,
    input  logic [LREG_W-1:0]    d_rd,
    input  logic                 d_need_to_wb,
    input  logic [RESULT_W-1:0]  d_result,
    input  logic [PAYLOAD_W-1:0] d_payload,
    output logic                 q_valid,
    output logic [LREG_W-1:0]    q_rd,
    output logic                 q_need_to_wb,
    output logic [RESULT_W-1:0]  q_result,
    output logic [PAYLOAD_W-1:0] q_payload
);

    // Load from predecessor (bubble forces valid low), otherwise hold with optional kill/fill.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_valid      <= 1'b0;
            q_rd         <= '0;
            q_need_to_wb <= 1'b0;
            q_result     <= '0;
            q_payload    <= '0;
        end else if (load) begin
            q_valid      <= d_valid & ~bubble;
            q_rd         <= d_rd;
            q_need_to_wb <= d_need_to_wb;
            q_result     <= d_result;
            q_payload    <= d_payload;
        end else begin
            if (kill)    q_valid  <= 1'b0;
            if (fill_en) q_result <= fill_data;
        end
    end

endmodule

// File: rtl/backend_pipe_ctrl.sv
// In-order backend pipeline shell: NSTAGE stages from exu to writeback/commit.
// Latency: NSTAGE cycles from acceptance to out_* with no stall; commit_valid one cycle later.
// Backpressure: in_ready drops while STALL_STAGE stalls; stages up to it hold, later stages get a bubble.
module backend_pipe_ctrl
    import backend_pipe_pkg::*;
#(
    parameter int NSTAGE      = DEF_NSTAGE,
    parameter int PAYLOAD_W   = DEF_PAYLOAD_W,
    parameter int RESULT_W    = DEF_RESULT_W,
    parameter int LREG_W      = DEF_LREG_W,
    parameter int STALL_STAGE = DEF_STALL_STAGE
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic [LREG_W-1:0]          in_rd,
    input  logic                       in_need_to_wb,
    input  logic [RESULT_W-1:0]        in_result,
    output logic                       in_ready,
    input  logic                       stall_req,
    input  logic                       upd_valid,
    input  logic [RESULT_W-1:0]        upd_data,
    input  logic                       flush_in,
    input  logic [NSTAGE-1:0]          flush_mask,
    output logic                       out_valid,
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [LREG_W-1:0]          out_rd,
    output logic                       out_need_to_wb,
    output logic [RESULT_W-1:0]        out_result,
    output logic [NSTAGE-1:0]          byp_valid,
    output logic [NSTAGE*LREG_W-1:0]   byp_rd,
    output logic [NSTAGE*RESULT_W-1:0] byp_result,
    output logic                       commit_valid,
    output logic [63:0]                commit_cnt,
    output logic [31:0]                stall_cnt
);

    localparam int WB = NSTAGE - 1;

    logic                 valid_q      [NSTAGE];
    logic [LREG_W-1:0]    rd_q         [NSTAGE];
    logic                 need_to_wb_q [NSTAGE];
    logic [RESULT_W-1:0]  result_q     [NSTAGE];
    logic [PAYLOAD_W-1:0] payload_q    [NSTAGE];
    logic [RESULT_W-1:0]  fwd_result   [NSTAGE];
    logic                 eff_stall;

    // A flushed stall stage never holds the pipe.
    assign eff_stall = stall_req & valid_q[STALL_STAGE] & ~flush_mask[STALL_STAGE];
    assign in_ready  = ~eff_stall;

    // Result seen downstream: load data overrides the stall stage's stored result.
    always_comb begin
        for (int i = 0; i < NSTAGE; i++) begin
            fwd_result[i] = result_q[i];
            if ((i == STALL_STAGE) && valid_q[i] && upd_valid) fwd_result[i] = upd_data;
        end
    end

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        logic                 ld;
        logic                 bub;
        logic                 dv;
        logic [LREG_W-1:0]    drd;
        logic                 dntw;
        logic [RESULT_W-1:0]  dres;
        logic [PAYLOAD_W-1:0] dpay;

        if (i == 0) begin : g_head
            assign ld   = ~eff_stall;
            assign bub  = flush_in;
            assign dv   = in_valid;
            assign drd  = in_rd;
            assign dntw = in_need_to_wb;
            assign dres = in_result;
            assign dpay = in_payload;
        end else begin : g_body
            // Stages up to the stall stage freeze together; the one after it takes a bubble.
            assign ld   = (i <= STALL_STAGE) ? ~eff_stall : 1'b1;
            assign bub  = flush_mask[i-1] | ((i == STALL_STAGE + 1) && eff_stall);
            assign dv   = valid_q[i-1];
            assign drd  = rd_q[i-1];
            assign dntw = need_to_wb_q[i-1];
            assign dres = fwd_result[i-1];
            assign dpay = payload_q[i-1];
        end

        pipe_stage_reg #(
            .PAYLOAD_W (PAYLOAD_W),
            .RESULT_W  (RESULT_W),
            .LREG_W    (LREG_W)
        ) u_stage (
            .clock        (clock),
            .reset_n      (reset_n),
            .load         (ld),
            .bubble       (bub),
            .kill         (flush_mask[i]),
            .fill_en      ((i == STALL_STAGE) && upd_valid && valid_q[i]),
            .fill_data    (upd_data),
            .d_valid      (dv),
            .d_rd         (drd),
            .d_need_to_wb (dntw),
            .d_result     (dres),
            .d_payload    (dpay),
            .q_valid      (valid_q[i]),
            .q_rd         (rd_q[i]),
            .q_need_to_wb (need_to_wb_q[i]),
            .q_result     (result_q[i]),
            .q_payload    (payload_q[i])
        );
    end

    assign out_valid      = valid_q[WB] & ~flush_mask[WB];
    assign out_payload    = payload_q[WB];
    assign out_rd         = rd_q[WB];
    assign out_need_to_wb = out_valid & need_to_wb_q[WB];
    assign out_result     = result_q[WB];

    // Flatten per-stage bypass taps; flushed entries are hidden the same cycle.
    always_comb begin
        byp_valid  = '0;
        byp_rd     = '0;
        byp_result = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            byp_valid[i]                     = valid_q[i] & need_to_wb_q[i] & ~flush_mask[i];
            byp_rd[i*LREG_W +: LREG_W]       = rd_q[i];
            byp_result[i*RESULT_W +: RESULT_W] = fwd_result[i];
        end
    end

    // Registered commit pulse and perf counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            commit_valid <= 1'b0;
            commit_cnt   <= '0;
            stall_cnt    <= '0;
        end else begin
            commit_valid <= out_valid;
            commit_cnt   <= commit_cnt + {63'd0, commit_valid};
            stall_cnt    <= sat_inc32(stall_cnt, eff_stall);
        end
    end

endmodule

// File: tb/tb_backend_pipe_ctrl.sv
// Directed self-checking bench for backend_pipe_ctrl at default parameters.
module tb_backend_pipe_ctrl;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic [255:0] in_payload;
    logic [4:0]   in_rd;
    logic         in_need_to_wb;
    logic [63:0]  in_result;
    logic         in_ready;
    logic         stall_req;
    logic         upd_valid;
    logic [63:0]  upd_data;
    logic         flush_in;
    logic [2:0]   flush_mask;
    logic         out_valid;
    logic [255:0] out_payload;
    logic [4:0]   out_rd;
    logic         out_need_to_wb;
    logic [63:0]  out_result;
    logic [2:0]   byp_valid;
    logic [14:0]  byp_rd;
    logic [191:0] byp_result;
    logic         commit_valid;
    logic [63:0]  commit_cnt;
    logic [31:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    backend_pipe_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_payload     (in_payload),
        .in_rd          (in_rd),
        .in_need_to_wb  (in_need_to_wb),
        .in_result      (in_result),
        .in_ready       (in_ready),
        .stall_req      (stall_req),
        .upd_valid      (upd_valid),
        .upd_data       (upd_data),
        .flush_in       (flush_in),
        .flush_mask     (flush_mask),
        .out_valid      (out_valid),
        .out_payload    (out_payload),
        .out_rd         (out_rd),
        .out_need_to_wb (out_need_to_wb),
        .out_result     (out_result),
        .byp_valid      (byp_valid),
        .byp_rd         (byp_rd),
        .byp_result     (byp_result),
        .commit_valid   (commit_valid),
        .commit_cnt     (commit_cnt),
        .stall_cnt      (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_payload    = '0;
        in_rd         = '0;
        in_need_to_wb = 1'b0;
        in_result     = '0;
        stall_req     = 1'b0;
        upd_valid     = 1'b0;
        upd_data      = '0;
        flush_in      = 1'b0;
        flush_mask    = '0;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [63:0] res);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_result     = res;
        in_need_to_wb = 1'b1;
        in_payload    = {192'd0, 59'd0, rd};
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        int e;
        reset_n = 1'b0;
        idle();
        #12;
        // Reset state
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_byp_valid", {61'd0, byp_valid}, 64'd0);
        check("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
        check("rst_commit_cnt", commit_cnt, 64'd0);
        check("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // 1: stream of four, no stall
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(5'(c + 1), 64'(10 * (c + 1)));
            else idle();
            tick();
            e = c + 1;
            check("s1_out_valid", {63'd0, out_valid}, {63'd0, (e >= 3 && e <= 6)});
            if (e >= 3 && e <= 6) begin
                check("s1_out_rd", {59'd0, out_rd}, 64'(e - 2));
                check("s1_out_result", out_result, 64'(10 * (e - 2)));
                check("s1_out_payload", out_payload[63:0], 64'(e - 2));
                check("s1_out_need_to_wb", {63'd0, out_need_to_wb}, 64'd1);
            end
            check("s1_commit_valid", {63'd0, commit_valid}, {63'd0, (e >= 4 && e <= 7)});
        end
        check("s1_commit_cnt", commit_cnt, 64'd4);
        check("s1_stall_cnt", {32'd0, stall_cnt}, 64'd0);

        // 2: load in stage 1 stalls 3 cycles, then fill
        drive(5'd5, 64'h11);
        tick();
        idle();
        tick();
        for (int k = 0; k < 3; k++) begin
            stall_req = 1'b1;
            #1;
            check("s2_in_ready_stall", {63'd0, in_ready}, 64'd0);
            check("s2_out_bubble", {63'd0, out_valid}, 64'd0);
            tick();
        end
        stall_req = 1'b0;
        upd_valid = 1'b1;
        upd_data  = 64'hABCD;
        #1;
        check("s2_in_ready_release", {63'd0, in_ready}, 64'd1);
        check("s2_byp_fill", byp_result[64 +: 64], 64'hABCD);
        tick();
        idle();
        #1;
        check("s2_out_valid", {63'd0, out_valid}, 64'd1);
        check("s2_out_rd", {59'd0, out_rd}, 64'd5);
        check("s2_out_result", out_result, 64'hABCD);
        check("s2_stall_cnt", {32'd0, stall_cnt}, 64'd3);
        drain();
        check("s2_commit_cnt", commit_cnt, 64'd5);

        // 3: flush stages 0 and 1 with three in flight
        drive(5'd8, 64'h80);
        tick();
        drive(5'd9, 64'h90);
        tick();
        drive(5'd10, 64'hA0);
        tick();
        idle();
        flush_mask = 3'b011;
        #1;
        check("s3_byp_valid", {61'd0, byp_valid}, 64'b100);
        check("s3_out_valid", {63'd0, out_valid}, 64'd1);
        check("s3_out_rd", {59'd0, out_rd}, 64'd8);
        tick();
        flush_mask = 3'b000;
        #1;
        check("s3_byp_after", {61'd0, byp_valid}, 64'd0);
        tick();
        check("s3_no_out_1", {63'd0, out_valid}, 64'd0);
        tick();
        check("s3_no_out_2", {63'd0, out_valid}, 64'd0);
        drain();
        check("s3_commit_cnt", commit_cnt, 64'd6);

        // 4: stall and flush on stage 1 together
        drive(5'd11, 64'hB0);
        tick();
        idle();
        tick();
        stall_req  = 1'b1;
        flush_mask = 3'b010;
        #1;
        check("s4_in_ready", {63'd0, in_ready}, 64'd1);
        check("s4_byp_valid1", {63'd0, byp_valid[1]}, 64'd0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            check("s4_no_out", {63'd0, out_valid}, 64'd0);
            tick();
        end
        check("s4_stall_cnt", {32'd0, stall_cnt}, 64'd3);
        check("s4_commit_cnt", commit_cnt, 64'd6);

        // 6: bypass tap on stage 1 with load fill
        drive(5'd7, 64'h99);
        tick();
        idle();
        tick();
        upd_valid = 1'b1;
        upd_data  = 64'd5;
        #1;
        check("s6_byp_valid1", {63'd0, byp_valid[1]}, 64'd1);
        check("s6_byp_rd1", {59'd0, byp_rd[5 +: 5]}, 64'd7);
        check("s6_byp_result1", byp_result[64 +: 64], 64'd5);
        tick();
        idle();
        check("s6_out_rd", {59'd0, out_rd}, 64'd7);
        check("s6_out_result", out_result, 64'd5);
        drain();
        check("s6_commit_cnt", commit_cnt, 64'd7);

        // 5: async reset in the middle of a stall
        drive(5'd12, 64'hC0);
        tick();
        idle();
        tick();
        stall_req = 1'b1;
        tick();
        tick();
        check("s5_stall_cnt", {32'd0, stall_cnt}, 64'd5);
        check("s5_in_ready_stall", {63'd0, in_ready}, 64'd0);
        #2 reset_n = 1'b0;
        #1;
        check("s5_byp_valid", {61'd0, byp_valid}, 64'd0);
        check("s5_out_valid", {63'd0, out_valid}, 64'd0);
        check("s5_commit_cnt", commit_cnt, 64'd0);
        check("s5_stall_cnt_rst", {32'd0, stall_cnt}, 64'd0);
        check("s5_in_ready_rst", {63'd0, in_ready}, 64'd1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        stall_req = 1'b0;
        tick();
        check("s5_in_ready_after", {63'd0, in_ready}, 64'd1);
        check("s5_out_after", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
